// File: rtl/ham_encoder_stream.sv
// Streaming Hamming encoder; optional overall parity bit via HAM_SECDED_EN.
// Latency: two register stages (S1 holds data, S2 holds codeword); one word per cycle.
// Backpressure: in_ready = !s1_valid || (!s2_valid || out_ready); full stages hold until drained.
module ham_encoder_stream #(
    parameter int M = 4,
    localparam int N = (1 << M) - 1,
    localparam int K = N - M,
`ifdef HAM_SECDED_EN
    localparam int CW = N + 1
`else
    localparam int CW = N
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [K-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_code,
    output logic [15:0]   cw_count
);

    // Positions (1-indexed j mapped to bit j-1) whose index has bit i set and
    // which carry data; parity bit i is the XOR of exactly these positions.
    function automatic logic [N-1:0] par_mask(input int i);
        logic [N-1:0] m;
        m = '0;
        for (int j = 1; j <= N; j++) begin
            if ((((j >> i) & 1) != 0) && ((j & (j - 1)) != 0)) begin
                m = m | ({{(N-1){1'b0}}, 1'b1} << (j - 1));
            end
        end
        return m;
    endfunction

    logic          s1_valid;
    logic [K-1:0]  s1_data;
    logic          s2_valid;
    logic [CW-1:0] s2_code;
    logic          s2_adv;

    logic [N-1:0]  dvec;       // data bits in place, parity slots zero
    logic [M-1:0]  par;
    logic [N-1:0]  base_code;  // Hamming codeword without overall parity
    logic [CW-1:0] code_n;

    // Position j: power of two carries parity log2(j); otherwise it carries the
    // data bit whose index is j minus the number of parity slots at or below j.
    for (genvar gj = 1; gj <= N; gj++) begin : g_pos
        if ((gj & (gj - 1)) == 0) begin : g_par_slot
            assign dvec[gj-1]      = 1'b0;
            assign base_code[gj-1] = par[$clog2(gj)];
        end else begin : g_data_slot
            assign dvec[gj-1]      = s1_data[gj - $clog2(gj) - 1];
            assign base_code[gj-1] = dvec[gj-1];
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_parity
        localparam logic [N-1:0] MASK = par_mask(gi);
        assign par[gi] = ^(dvec & MASK);
    end

`ifdef HAM_SECDED_EN
    assign code_n = {^base_code, base_code};
`else
    assign code_n = base_code;
`endif

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;
    assign out_code  = s2_code;

    // S1: capture an offered word whenever the stage can move; empty otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    // S2: register the encoded codeword when the output slot is free or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_code  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_code <= code_n;
            end
        end
    end

    // Delivered-codeword counter, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_count <= 16'h0000;
        end else if (s2_valid && out_ready) begin
            cw_count <= cw_count + 16'd1;
        end
    end

endmodule
